// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM: byte-enabled write port A, registered read port B, and a clear sweep to INIT_VALUE.
// Define RAM_WR_FWD_EN for write-first data on same-address collisions (read-first otherwise).
module ram_dp_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic                    b_cs,
    input  logic                    b_oe,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    a_in_range;
    logic                    b_in_range;
    logic                    wr_from_a;
    logic                    rd_en;
    logic [NB-1:0]           wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign a_in_range = ({1'b0, a_addr} < DEPTH_W);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_W);

    // A clr pulse in READY discards any port activity sampled on the same edge.
    assign wr_from_a = !rst && (state == READY) && !clr && a_cs && a_we && a_in_range;
    assign rd_en     = (state == READY) && !clr && b_cs && b_oe;

    always_comb begin
        wr_en   = '0;
        wr_idx  = '0;
        wr_data = '0;
        if (!rst && state == CLEAR) begin
            wr_en   = '1;
            wr_idx  = cnt[IDX_W-1:0];
            wr_data = INIT_VALUE;
        end else if (wr_from_a) begin
            wr_en   = a_be;
            wr_idx  = a_addr[IDX_W-1:0];
            wr_data = a_din;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Read data is taken before this edge's write lands, giving read-first by default.
    always_comb begin
        rd_word = b_in_range ? mem[b_addr[IDX_W-1:0]] : '0;
`ifdef RAM_WR_FWD_EN
        if (wr_from_a && b_in_range && (a_addr == b_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) rd_word[8*i +: 8] = a_din[8*i +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            busy    <= 1'b1;
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    b_valid <= 1'b0;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clr) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        b_valid <= 1'b0;
                    end else begin
                        b_valid <= rd_en;
                        if (rd_en) b_dout <= rd_word;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    b_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised simple dual-port RAM. Port A is write-only with byte enables; port B is read-only with registered output and a valid strobe.
- A built-in clear sequencer sweeps every word to INIT_VALUE after reset or on request, and holds the block busy while it runs.
- Successor to the single-port cs/we/oe bidirectional-bus memory. It replaces the tristate bus with separate data paths for on-chip use.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width.
- RAM_DEPTH, 16, number of words; must satisfy 2 <= RAM_DEPTH <= 2**ADDR_WIDTH.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sweep.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  pulse; starts a clear sweep when READY.
- a_cs  input  1  port A select.
- a_we  input  1  port A write enable.
- a_addr  input  ADDR_WIDTH  write address.
- a_din  input  DATA_WIDTH  write data.
- a_be  input  DATA_WIDTH/8  byte enables; bit i covers bits 8i+7:8i.
- b_cs  input  1  port B select.
- b_oe  input  1  port B read enable.
- b_addr  input  ADDR_WIDTH  read address.
- b_dout  output  DATA_WIDTH  registered read data.
- b_valid  output  1  b_dout updated this cycle.
- busy  output  1  clear sweep in progress.

Behaviour:
- FSM has two states: CLEAR and READY.
- rst high at an edge:
  - state <= CLEAR, sweep counter <= 0, busy <= 1, b_dout <= 0, b_valid <= 0.
  - rst has priority over every other input.
- CLEAR:
  - Each edge with rst low writes INIT_VALUE to mem[counter], then increments the counter.
  - On the edge that writes address RAM_DEPTH-1: state <= READY, busy <= 0.
  - Result: busy is high for exactly RAM_DEPTH cycles after rst falls.
  - Port A writes, port B reads and clr are all ignored. b_valid stays 0 and b_dout holds its value.
- rst asserted mid-sweep restarts the sweep at address 0.
- READY + clr=1: same transition as reset into CLEAR (counter 0, busy 1). b_dout keeps its last value.
  - Any port A write or port B read sampled on that same edge is discarded.
- Write: in READY, a_cs && a_we && a_addr < RAM_DEPTH.
  - Bytes with a_be[i]=1 take a_din; other bytes are unchanged. Committed at that edge.
  - a_addr >= RAM_DEPTH: write dropped, no side effects.
  - a_be=0: no change.
- Read: in READY, b_cs && b_oe.
  - Next edge: b_dout <= mem[b_addr], b_valid <= 1. Read latency is 1 cycle.
  - b_addr >= RAM_DEPTH returns 0 with b_valid=1.
  - Otherwise b_valid <= 0 and b_dout holds its previous value (never forced to 0 outside reset).
  - Back-to-back reads: one result per cycle.
- Same-address collision (write and read same address, same edge):
  - Read-first: b_dout returns the pre-write word.
  - Different addresses are fully independent.
- Memory contents are not touched by rst except through the sweep it starts.

Optional Feature:
- Macro: RAM_WR_FWD_EN.
- Defined: on a same-address collision, b_dout returns write-first data. Bytes with a_be[i]=1 come from a_din; the rest come from stored data. b_valid behaves as normal.
- Undefined: read-first as specified above; no forwarding mux is synthesised.

Test Plan:
- Clear timing: rst high 2 cycles then low.
  - busy=1 for exactly 16 cycles, then 0.
  - Reads of addresses 0..15 then return 0x0000 with b_valid=1 one cycle after each request.
- Byte-enable write:
  - Write 0xABCD to addr 3 with a_be=11. Then write 0x1200 with a_be=10.
  - Read addr 3 -> 0x12CD.
- Collision: mem[5]=0x1111; same edge write 0x2222 (a_be=11) to addr 5 and read addr 5.
  - b_dout=0x1111 without RAM_WR_FWD_EN; 0x2222 with it.
  - Next read of addr 5 -> 0x2222 in both builds.
- Runtime clear and out of range:
  - Fill mem with 0xFFFF, pulse clr together with a write to addr 7.
  - busy high 16 cycles; write discarded; read addr 7 -> 0x0000.
  - Write to addr 16 with ADDR_WIDTH=5 and RAM_DEPTH=16 has no effect; read of addr 16 -> 0x0000.
- Reset mid-sweep and while idle:
  - Assert rst at sweep count 9: busy stays high and runs 16 fresh cycles after rst falls.
  - b_valid=0 throughout.
  - Read requests during busy produce no b_valid.
- Streaming reads:
  - b_cs=b_oe=1 for 4 cycles on addrs 0,1,2,3, preloaded 0x0010..0x0013.
  - b_valid high 4 consecutive cycles with 0x0010..0x0013 in order.
  - b_valid low next cycle with b_dout held at 0x0013.
